// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and byte/acknowledge constants for the I2C target.
package i2c_pkg;
   localparam int I2C_BYTE_W = 8;
   localparam logic ACK = 1'b0;
   localparam logic NACK = 1'b1;
   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK,
      S_IGNORE
   } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_line_sync #(
   parameter int SYNC_FF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   logic [SYNC_FF-1:0] scl_q, sda_q;
   logic scl_p_q, sda_p_q, scl_s;
   // Preset to 1 so reset looks like an idle bus and creates no false edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_q <= '1;
         sda_q <= '1;
         scl_p_q <= 1'b1;
         sda_p_q <= 1'b1;
      end else begin
         scl_q <= {scl_q[SYNC_FF-2:0], scl_i};
         sda_q <= {sda_q[SYNC_FF-2:0], sda_i};
         scl_p_q <= scl_s;
         sda_p_q <= sda_o;
      end
   end
   assign scl_s = scl_q[SYNC_FF-1];
   assign sda_o = sda_q[SYNC_FF-1];
   assign scl_rise_o = scl_s & ~scl_p_q;
   assign scl_fall_o = ~scl_s & scl_p_q;
   assign start_o = scl_s & scl_p_q & sda_p_q & ~sda_o;
   assign stop_o = scl_s & scl_p_q & ~sda_p_q & sda_o;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with address match and register pointer, exposing
// byte writes/reads to a local register bank via single-cycle strobes.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int SYNC_FF = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_stb,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);
   state_t state_q, state_d;
   logic [3:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
   logic sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, mack_q, mack_d;
   logic wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
   logic sda_s, scl_rise, scl_fall, start, stop, byte_done, addr_hit;

   i2c_line_sync #(.SYNC_FF(SYNC_FF)) u_sync (
      .clk(clk),
      .reset(reset),
      .scl_i(scl_i),
      .sda_i(sda_i),
      .sda_o(sda_s),
      .scl_rise_o(scl_rise),
      .scl_fall_o(scl_fall),
      .start_o(start),
      .stop_o(stop)
   );

   assign byte_done = scl_fall && bitcnt_q == 4'(I2C_BYTE_W);
   assign addr_hit = shift_q[7:1] == DEV_ADDR;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         bitcnt_q <= '0;
         shift_q <= '0;
         ptr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         sda_oe_q <= 1'b0;
         busy_q <= 1'b0;
         rw_q <= 1'b0;
         mack_q <= NACK;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q <= shift_d;
         ptr_q <= ptr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
         sda_oe_q <= sda_oe_d;
         busy_q <= busy_d;
         rw_q <= rw_d;
         mack_q <= mack_d;
         wr_stb_q <= wr_stb_d;
         rd_stb_q <= rd_stb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bitcnt_d = bitcnt_q;
      shift_d = shift_q;
      ptr_d = ptr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      sda_oe_d = sda_oe_q;
      busy_d = busy_q;
      rw_d = rw_q;
      mack_d = mack_q;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
         busy_d = 1'b0;
      end else if (start) begin
         state_d = S_ADDR;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
      end else if (rd_stb_q) begin
         // Fetched byte arrives the clock after the strobe; drive its MSB while SCL is low.
         shift_d = rd_data;
         sda_oe_d = ~rd_data[7];
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  bitcnt_d = bitcnt_q + 4'd1;
               end
               if (byte_done) begin
                  bitcnt_d = '0;
                  sda_oe_d = 1'b1;
                  if (state_q == S_ADDR) begin
                     state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
                     sda_oe_d = addr_hit;
                     busy_d = addr_hit;
                     rw_d = shift_q[0];
                  end else if (state_q == S_PTR) begin
                     state_d = S_PTR_ACK;
                     ptr_d = shift_q;
                  end else begin
                     state_d = S_WDATA_ACK;
                     wr_stb_d = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = shift_q;
                     ptr_d = ptr_q + 8'd1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  bitcnt_d = '0;
                  state_d = rw_q ? S_RDATA : S_PTR;
                  rd_stb_d = rw_q;
                  rd_addr_d = rw_q ? ptr_q : rd_addr_q;
                  ptr_d = rw_q ? ptr_q + 8'd1 : ptr_q;
               end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d = S_WDATA;
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'(I2C_BYTE_W - 1)) begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = '0;
                     state_d = S_RDATA_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                     bitcnt_d = bitcnt_q + 4'd1;
                  end
               end
            end
            S_RDATA_ACK: begin
               if (scl_rise) mack_d = sda_s;
               if (scl_fall) begin
                  state_d = (mack_q == ACK) ? S_RDATA : S_IGNORE;
                  rd_stb_d = mack_q == ACK;
                  rd_addr_d = (mack_q == ACK) ? ptr_q : rd_addr_q;
                  ptr_d = (mack_q == ACK) ? ptr_q + 8'd1 : ptr_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe = sda_oe_q;
   assign busy = busy_q;
   assign wr_stb = wr_stb_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rd_stb = rd_stb_q;
   assign rd_addr = rd_addr_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level I2C master model with strobe scoreboard and random traffic.
module tb_i2c_target_regs;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sda_line;
   logic sda_oe, wr_stb, rd_stb, busy;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] mptr;
   logic oe_seen = 1'b0;
   logic busy_seen = 1'b0;
   logic oe_prev = 1'b0;

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;
   assign rd_data = rd_addr + 8'h20;

   i2c_target_regs dut (
      .clk(clk),
      .reset(reset),
      .scl_i(scl_m),
      .sda_i(sda_line),
      .sda_oe(sda_oe),
      .wr_stb(wr_stb),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_stb(rd_stb),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (wr_stb) begin
            chk("wr_stb_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) chk("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
         end
         if (rd_stb) begin
            chk("rd_stb_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) chk("rd_addr", rd_addr, exp_rd.pop_front());
         end
         if (wr_stb || rd_stb) chk("single_strobe", wr_stb & rd_stb, 0);
         if (sda_oe !== oe_prev) chk("oe_change_scl_low", scl_m, 0);
         if (sda_oe) oe_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
      oe_prev = sda_oe;
   end

   task automatic q();
      repeat (8) @(negedge clk);
   endtask

   task automatic do_start();
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic do_stop();
      sda_m = 1'b0; q();
      scl_m = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic bit_x(input logic b, output logic r);
      sda_m = b; q();
      scl_m = 1'b1; q();
      r = sda_line; q();
      scl_m = 1'b0; q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_x(b[i], r);
      bit_x(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
      bit_x(nack, r);
   endtask

   task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input int n, input logic [7:0] d[4]);
      logic ack, hit;
      hit = (a == 7'h3C);
      if (hit) begin
         mptr = p;
         for (int i = 0; i < n; i++) begin
            exp_wr.push_back({mptr, d[i]});
            mptr = mptr + 8'd1;
         end
      end
      do_start();
      send_byte({a, 1'b0}, ack);
      chk("addr_ack", ack, !hit);
      chk("busy_after_addr", busy, hit);
      send_byte(p, ack);
      chk("ptr_ack", ack, !hit);
      for (int i = 0; i < n; i++) begin
         send_byte(d[i], ack);
         chk("data_ack", ack, !hit);
      end
      do_stop();
      chk("busy_after_stop", busy, 0);
      chk("wr_queue_drained", exp_wr.size(), 0);
   endtask

   task automatic rd_txn(input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] d;
      logic [7:0] expb[$];
      do_start();
      send_byte(8'h78, ack);
      chk("rd_waddr_ack", ack, 0);
      send_byte(p, ack);
      chk("rd_ptr_ack", ack, 0);
      mptr = p;
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(mptr);
         expb.push_back(mptr + 8'h20);
         mptr = mptr + 8'd1;
      end
      do_start();
      send_byte(8'h79, ack);
      chk("rd_raddr_ack", ack, 0);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         chk("rd_byte", d, expb[i]);
      end
      chk("oe_after_nack", sda_oe, 0);
      do_stop();
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("rd_busy_after_stop", busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic r;
      logic [7:0] b;
      logic [7:0] d[4];
      repeat (4) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {wr_stb, rd_stb}, 0);
      chk("rst_wr_bus", {wr_addr, wr_data}, 0);
      chk("rst_rd_addr", rd_addr, 0);
      reset = 1'b1;
      q();
      wr_txn(7'h3C, 8'h10, 2, '{8'hA5, 8'h5A, 8'h00, 8'h00});
      rd_txn(8'h20, 3);
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      wr_txn(7'h3D, 8'h55, 0, '{8'h00, 8'h00, 8'h00, 8'h00});
      chk("foreign_no_oe", oe_seen, 0);
      chk("foreign_no_busy", busy_seen, 0);
      wr_txn(7'h3C, 8'hFF, 2, '{8'h11, 8'h22, 8'h00, 8'h00});
      do_start();
      send_byte(8'h78, r);
      chk("partial_addr_ack", r, 0);
      send_byte(8'h40, r);
      b = 8'hC3;
      for (int i = 7; i >= 4; i--) bit_x(b[i], r);
      do_stop();
      wr_txn(7'h3C, 8'h40, 1, '{8'h9E, 8'h00, 8'h00, 8'h00});
      do_start();
      b = 8'h78;
      for (int i = 7; i >= 0; i--) bit_x(b[i], r);
      chk("oe_in_ack_slot", sda_oe, 1);
      reset = 1'b0;
      #1;
      chk("oe_async_reset", sda_oe, 0);
      chk("busy_async_reset", busy, 0);
      @(negedge clk);
      scl_m = 1'b1;
      sda_m = 1'b1;
      q();
      reset = 1'b1;
      q();
      wr_txn(7'h3C, 8'h10, 2, '{8'hA5, 8'h5A, 8'h00, 8'h00});
      for (int k = 0; k < 20; k++) begin
         int kind;
         logic [6:0] a;
         kind = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         if (kind < 2) wr_txn(7'h3C, 8'($urandom), $urandom_range(1, 4), d);
         else if (kind == 2) rd_txn(8'($urandom), $urandom_range(1, 3));
         else begin
            a = 7'($urandom);
            if (a == 7'h3C) a = 7'h3D;
            wr_txn(a, 8'($urandom), $urandom_range(0, 2), d);
         end
      end
      q();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
